// File: rtl/tx_scheduler.sv
// tx_scheduler: two-requester byte scheduler feeding a serial transmitter.
// Ports: clk, rst (sync, active-low), req0/data0, req1/data1 in;
//        data, send, ack0, ack1, busy out (all registered).
// Parameter FRAME_CYCLES: transmitter cycles per frame (1..255).
// Macro TX_SCHED_RR_EN: round-robin on ties (else requester 0 wins).
module tx_scheduler #(
    parameter int unsigned FRAME_CYCLES = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [7:0] data0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic [7:0] data,
    output logic       send,
    output logic       ack0,
    output logic       ack1,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [7:0] data_n;
    logic       send_n, ack0_n, ack1_n, busy_n;
    logic       gnt1;

`ifdef TX_SCHED_RR_EN
    // last1: requester 1 won the most recent grant
    logic last1, last1_n;
    assign gnt1 = req1 & (~req0 | ~last1);
`else
    assign gnt1 = req1 & ~req0;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        data_n  = data;
        send_n  = 1'b0;
        ack0_n  = 1'b0;
        ack1_n  = 1'b0;
        busy_n  = busy;
`ifdef TX_SCHED_RR_EN
        last1_n = last1;
`endif
        unique case (state)
            IDLE: begin
                busy_n = 1'b0;
                if (req0 | req1) begin
                    state_n = SEND;
                    data_n  = gnt1 ? data1 : data0;
                    send_n  = 1'b1;
                    ack0_n  = ~gnt1;
                    ack1_n  = gnt1;
                    busy_n  = 1'b1;
                    cnt_n   = 8'(FRAME_CYCLES - 1);
`ifdef TX_SCHED_RR_EN
                    last1_n = gnt1;
`endif
                end
            end
            SEND: begin
                state_n = WAIT;
                busy_n  = 1'b1;
            end
            WAIT: begin
                busy_n = 1'b1;
                // cnt counts FRAME_CYCLES-1 down to 0: WAIT spans one frame
                if (cnt == 8'd0) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 8'd0;
            data  <= 8'h00;
            send  <= 1'b0;
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            busy  <= 1'b0;
`ifdef TX_SCHED_RR_EN
            last1 <= 1'b1;
`endif
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            data  <= data_n;
            send  <= send_n;
            ack0  <= ack0_n;
            ack1  <= ack1_n;
            busy  <= busy_n;
`ifdef TX_SCHED_RR_EN
            last1 <= last1_n;
`endif
        end
    end

endmodule

// File: tb/tb_tx_scheduler.sv
// tb_tx_scheduler: random + directed stimulus against a timeline model.
// Two DUTs share inputs: FRAME_CYCLES=10 and FRAME_CYCLES=1.
module tb_tx_scheduler;

`ifdef TX_SCHED_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [7:0] data0 = 8'h00;
    logic [7:0] data1 = 8'h00;

    logic [7:0] d_data [2];
    logic       d_send [2];
    logic       d_ack0 [2];
    logic       d_ack1 [2];
    logic       d_busy [2];

    always #5 clk = ~clk;

    tx_scheduler #(.FRAME_CYCLES(10)) u_a (
        .clk(clk), .rst(rst),
        .req0(req0), .data0(data0),
        .req1(req1), .data1(data1),
        .data(d_data[0]), .send(d_send[0]),
        .ack0(d_ack0[0]), .ack1(d_ack1[0]),
        .busy(d_busy[0])
    );

    tx_scheduler #(.FRAME_CYCLES(1)) u_b (
        .clk(clk), .rst(rst),
        .req0(req0), .data0(data0),
        .req1(req1), .data1(data1),
        .data(d_data[1]), .send(d_send[1]),
        .ack0(d_ack0[1]), .ack1(d_ack1[1]),
        .busy(d_busy[1])
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     tag, obs, exp, $time);
        end
    endtask

    // Timeline model: each grant at edge e occupies the
    // scheduler until edge e+FC+2, busy after edges e..e+FC.
    int         fc [2] = '{10, 1};
    int         cyc = 0;
    int         free_at [2];
    int         busy_til [2];
    bit         last1 [2];
    logic [7:0] m_data [2];
    bit         m_send [2];
    bit         m_ack0 [2];
    bit         m_ack1 [2];
    bit         in_reset_seen = 1'b0;

    task automatic model_edge();
        bit w1;
        for (int i = 0; i < 2; i++) begin
            m_send[i] = 1'b0;
            m_ack0[i] = 1'b0;
            m_ack1[i] = 1'b0;
            if (!rst) begin
                m_data[i]   = 8'h00;
                free_at[i]  = cyc + 1;
                busy_til[i] = cyc - 1;
                last1[i]    = 1'b1;
            end else if (cyc >= free_at[i] && (req0 || req1)) begin
                w1 = req1 && (!req0 || (RR && !last1[i]));
                last1[i]    = w1;
                m_data[i]   = w1 ? data1 : data0;
                m_send[i]   = 1'b1;
                m_ack0[i]   = !w1;
                m_ack1[i]   = w1;
                busy_til[i] = cyc + fc[i];
                free_at[i]  = cyc + fc[i] + 2;
            end
        end
        if (!rst) in_reset_seen = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        if (in_reset_seen) begin
            for (int i = 0; i < 2; i++) begin
                string s;
                s = (i == 0) ? "fc10" : "fc1";
                chk({s, ".data"}, 32'(d_data[i]), 32'(m_data[i]));
                chk({s, ".send"}, 32'(d_send[i]), 32'(m_send[i]));
                chk({s, ".ack0"}, 32'(d_ack0[i]), 32'(m_ack0[i]));
                chk({s, ".ack1"}, 32'(d_ack1[i]), 32'(m_ack1[i]));
                chk({s, ".busy"}, 32'(d_busy[i]),
                    32'(cyc <= busy_til[i]));
                chk({s, ".onehot"}, 32'(d_ack0[i] & d_ack1[i]), 32'd0);
            end
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        // reset
        rst = 1'b0;
        run(3);
        rst = 1'b1;

        // single byte A5, one-cycle request
        req0 = 1'b1; data0 = 8'hA5;
        tick();
        req0 = 1'b0;
        run(20);

        // both held high
        req0 = 1'b1; data0 = 8'h11;
        req1 = 1'b1; data1 = 8'h22;
        run(50);
        req0 = 1'b0; req1 = 1'b0;
        run(15);

        // req1 raised 3 cycles after a req0 grant
        req0 = 1'b1; data0 = 8'h5A;
        tick();
        req0 = 1'b0;
        run(3);
        req1 = 1'b1; data1 = 8'hC3;
        run(12);
        req1 = 1'b0;
        run(15);

        // reset 4 cycles into WAIT
        req0 = 1'b1; data0 = 8'h77;
        tick();
        req0 = 1'b0;
        run(5);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        run(20);

        // random traffic with occasional resets
        for (int k = 0; k < 1500; k++) begin
            req0  = ($urandom_range(0, 99) < 40);
            req1  = ($urandom_range(0, 99) < 40);
            data0 = 8'($urandom);
            data1 = 8'($urandom);
            rst   = ($urandom_range(0, 59) != 0);
            tick();
        end
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        run(15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tx_scheduler.md
TX_SCHEDULER -- requirements
Module: tx_scheduler

Interface
REQ-001 Parameter FRAME_CYCLES, default 10, SHALL set the number of clk cycles the serial transmitter needs per frame (start + 8 data + stop); legal range 1..255.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-low.
REQ-004 req0  input  1  SHALL be requester 0 level request (byte on data0 valid while high).
REQ-005 data0  input  8  SHALL be requester 0 byte.
REQ-006 req1  input  1  SHALL be requester 1 level request.
REQ-007 data1  input  8  SHALL be requester 1 byte.
REQ-008 data  output  8  SHALL be the byte presented to the transmitter's data input.
REQ-009 send  output  1  SHALL be the one-cycle start pulse to the transmitter's send input.
REQ-010 ack0  output  1  SHALL be a one-cycle pulse: requester 0 byte accepted.
REQ-011 ack1  output  1  SHALL be a one-cycle pulse: requester 1 byte accepted.
REQ-012 busy  output  1  SHALL be high from grant until the frame slot ends.

Function
REQ-013 FSM SHALL have states IDLE, SEND, WAIT; all outputs SHALL be registered.
REQ-014 IDLE: if req0 or req1 sampled high, the next edge SHALL go to SEND, latch the winner's byte into data, set send=1, ack of winner=1, busy=1, load cnt=FRAME_CYCLES-1.
REQ-015 IDLE with no request SHALL stay in IDLE with send=0, ack0=ack1=0, busy=0.
REQ-016 SEND SHALL last exactly one cycle, then go to WAIT with send=0 and both acks 0.
REQ-017 WAIT SHALL decrement cnt each cycle; cnt==0 in WAIT SHALL return to IDLE on the next edge with busy=0; WAIT therefore lasts FRAME_CYCLES cycles.
REQ-018 With a continuous request, consecutive send pulses SHALL be exactly FRAME_CYCLES+2 cycles apart.
REQ-019 data SHALL hold the last granted byte until the next grant; it SHALL NOT change in SEND or WAIT.
REQ-020 Requests seen in SEND or WAIT SHALL be ignored (no ack); a request still high on return to IDLE SHALL be arbitrated then.
REQ-021 A req still high in the cycle after its ack SHALL count as a new request; requesters drop req on ack to send one byte.
REQ-022 At most one of ack0, ack1 SHALL be high in any cycle, and never outside the SEND cycle.
REQ-023 Arbitration when both requests are high SHALL follow REQ-029/REQ-030; a single request SHALL always win.

Reset
REQ-024 rst low at a rising edge SHALL force IDLE, data=8'h00, send=0, ack0=ack1=0, busy=0, cnt=0, round-robin pointer = "last granted 1".
REQ-025 Reset in SEND or WAIT SHALL abort the slot at once; no ack or send SHALL follow for the aborted grant.
REQ-026 First grant after reset release SHALL take place no earlier than the first edge with rst high.

Configuration
REQ-027 Macro TX_SCHED_RR_EN SHALL select the arbitration policy at compile time.
REQ-028 The policy choice SHALL NOT change the port list, the timing or REQ-013..REQ-022.
REQ-029 With TX_SCHED_RR_EN defined: round-robin; on a tie the requester not granted last SHALL win; the pointer SHALL update on every grant.
REQ-030 Without TX_SCHED_RR_EN: fixed priority; on a tie requester 0 SHALL always win; the pointer SHALL NOT exist.

Verification
REQ-031 After reset, req0=1 data0=8'hA5 for one cycle -> next cycle send=1, ack0=1, data=8'hA5; busy high 11 cycles; data stays 8'hA5 afterwards.
REQ-032 req0 and req1 both held high, data0=8'h11 data1=8'h22, RR build -> sends 8'h11, 8'h22, 8'h11, 8'h22, send pulses 12 cycles apart; fixed build -> 8'h11 only.
REQ-033 req1 raised 3 cycles after a req0 grant -> no ack1 during WAIT; ack1 and send exactly 12 cycles after the first send.
REQ-034 rst low 4 cycles into WAIT -> next edge busy=0, data=8'h00; with no request, no further send.
REQ-035 FRAME_CYCLES=1, req0 held high -> send pulses every 3 cycles, one ack0 per pulse, never both acks high.
REQ-036 Connect data and send to state_machine with a shared clk/rst; issue 8'h4D then 8'h3C -> txd shows two complete non-overlapping frames in order.
